// File: rtl/tdm_demux.sv
// 1:2 time-division demultiplexer: collects a sync-marked 2*WIDTH-bit serial frame
// and presents channel A (first half) and channel B (second half) words with a valid pulse.
module tdm_demux #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             sync,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             valid,
   output logic             err
);

   localparam int unsigned FW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(FW);
   localparam logic [CW-1:0] LastBit = CW'(FW - 1);

   typedef enum logic {StHunt, StRecv} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [FW-1:0]   sr_q, sr_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic [FW-1:0]   frame;

   // Shift register contents including the bit sampled on this edge.
   assign frame = {sr_q[FW-2:0], din};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      a_d     = a_q;
      b_d     = b_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         StHunt: begin
            if (sync) begin
               sr_d    = frame;
               cnt_d   = CW'(1);
               state_d = StRecv;
            end
         end
         StRecv: begin
            sr_d = frame;
            if (sync) begin
               // Early sync aborts the partial frame and restarts on this bit.
               err_d = 1'b1;
               cnt_d = CW'(1);
            end else if (cnt_q == LastBit) begin
               a_d     = frame[FW-1:WIDTH];
               b_d     = frame[WIDTH-1:0];
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = StHunt;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = StHunt;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StHunt;
         cnt_q   <= '0;
         sr_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign a     = a_q;
   assign b     = b_q;
   assign valid = valid_q;
   assign err   = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux (WIDTH=4): directed vector table, hand-built corner sequences and
// random traffic, all compared against a bit-queue reference model.
module tb_tdm_demux;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         din;
   logic         sync;
   logic [W-1:0] a, b;
   logic         valid, err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model state
   bit    m_busy;
   int    m_bits[$];
   int    m_a, m_b;
   bit    m_valid, m_err;

   typedef struct {
      bit s;
      bit d;
      bit ev;
      bit ee;
      int ea;
      int eb;
   } vec_t;
   vec_t vecs[$];

   tdm_demux #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .sync (sync),
      .a    (a),
      .b    (b),
      .valid(valid),
      .err  (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_busy = 0; m_bits = {}; m_a = 0; m_b = 0; m_valid = 0; m_err = 0;
   endfunction

   function automatic void model_step(input bit s, input bit d);
      m_valid = 0;
      m_err   = 0;
      if (s) begin
         if (m_busy) m_err = 1;
         m_bits = {};
         m_bits.push_back(int'(d));
         m_busy = 1;
      end else if (m_busy) begin
         m_bits.push_back(int'(d));
      end
      if (m_bits.size() == 2 * W) begin
         m_a = 0;
         m_b = 0;
         for (int i = 0; i < W; i++) begin
            m_a += m_bits[i] * (1 << (W - 1 - i));
            m_b += m_bits[W + i] * (1 << (W - 1 - i));
         end
         m_valid = 1;
         m_busy  = 0;
         m_bits  = {};
      end
   endfunction

   // Apply inputs, clock once, sample 1 ns after the edge and compare against the model.
   task automatic step(input bit s, input bit d);
      sync = s;
      din  = d;
      @(posedge clk);
      #1;
      cyc++;
      model_step(s, d);
      check("a", int'(a), m_a);
      check("b", int'(b), m_b);
      check("valid", int'(valid), int'(m_valid));
      check("err", int'(err), int'(m_err));
      check("valid_err_excl", int'(valid & err), 0);
   endtask

   task automatic send_frame(input int fa, input int fb);
      for (int i = 0; i < 2 * W; i++) begin
         if (i < W) step(i == 0, bit'((fa >> (W - 1 - i)) & 1));
         else       step(1'b0, bit'((fb >> (2 * W - 1 - i)) & 1));
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_a"}, int'(a), 0);
      check({name, "_b"}, int'(b), 0);
      check({name, "_valid"}, int'(valid), 0);
      check({name, "_err"}, int'(err), 0);
   endtask

   initial begin
      int first_v, second_v;
      int hold_a, hold_b;
      bit dv;

      rst = 1'b1; sync = 1'b0; din = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // Single frame A=A, B=5; sync on the very first edge after reset release.
      begin
         bit bits[8];
         bits = '{1, 0, 1, 0, 0, 1, 0, 1};
         for (int i = 0; i < 8; i++)
            vecs.push_back('{s: (i == 0), d: bits[i], ev: (i == 7), ee: 0,
                             ea: (i == 7) ? 'hA : 0, eb: (i == 7) ? 'h5 : 0});
         vecs.push_back('{s: 0, d: 0, ev: 0, ee: 0, ea: 'hA, eb: 'h5});
      end
      foreach (vecs[i]) begin
         step(vecs[i].s, vecs[i].d);
         check("vec_a", int'(a), vecs[i].ea);
         check("vec_b", int'(b), vecs[i].eb);
         check("vec_valid", int'(valid), int'(vecs[i].ev));
         check("vec_err", int'(err), int'(vecs[i].ee));
      end

      // Back-to-back frames: 3/C then F/0, valid pulses exactly 8 cycles apart.
      send_frame('h3, 'hC);
      first_v = cyc;
      check("b2b_v1", int'(valid), 1);
      check("b2b_a1", int'(a), 'h3);
      check("b2b_b1", int'(b), 'hC);
      send_frame('hF, 'h0);
      second_v = cyc;
      check("b2b_v2", int'(valid), 1);
      check("b2b_a2", int'(a), 'hF);
      check("b2b_b2", int'(b), 'h0);
      check("b2b_spacing", second_v - first_v, 8);

      // Abort at bit 5: err pulse, a/b held, restarted frame 2/7 completes 8 edges later.
      for (int i = 0; i < 5; i++) step(i == 0, bit'(i & 1));
      hold_a = int'(a);
      hold_b = int'(b);
      step(1'b1, 1'b0);
      check("abort_err", int'(err), 1);
      check("abort_valid", int'(valid), 0);
      check("abort_a_hold", int'(a), hold_a);
      check("abort_b_hold", int'(b), hold_b);
      begin
         bit nb[8];
         nb = '{0, 0, 1, 0, 0, 1, 1, 1};
         for (int i = 1; i < 8; i++) begin
            step(1'b0, nb[i]);
            if (i < 7) check("abort_no_valid", int'(valid), 0);
         end
      end
      check("restart_valid", int'(valid), 1);
      check("restart_a", int'(a), 'h2);
      check("restart_b", int'(b), 'h7);

      // Reset at bit 3 for two cycles; leftover bits must not produce valid.
      for (int i = 0; i < 3; i++) step(i == 0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("midrst_hold");
      rst = 1'b0;
      for (int i = 3; i < 8; i++) begin
         step(1'b0, bit'(i & 1));
         check("midrst_no_valid", int'(valid), 0);
      end

      // Idle: 20 toggling din cycles with sync low from HUNT.
      send_frame('h9, 'h6);
      hold_a = int'(a);
      hold_b = int'(b);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, bit'(i & 1));
         check("idle_valid", int'(valid), 0);
         check("idle_err", int'(err), 0);
         check("idle_a", int'(a), hold_a);
         check("idle_b", int'(b), hold_b);
      end

      // Random traffic with sparse syncs (some early, forcing aborts).
      for (int i = 0; i < 600; i++) begin
         dv = bit'($urandom_range(0, 1));
         step($urandom_range(0, 8) == 0, dv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001: Parameter WIDTH, default 4, bits per channel word; legal range 2..16.
REQ-002: clk  input  1  single clock; all state changes on the rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: din  input  1  serial time-multiplexed data bit, sampled every rising edge.
REQ-005: sync  input  1  frame marker; high in the cycle that carries frame bit 0.
REQ-006: a  output  WIDTH  channel A word, registered.
REQ-007: b  output  WIDTH  channel B word, registered.
REQ-008: valid  output  1  registered one-cycle pulse marking fresh a/b.
REQ-009: err  output  1  registered one-cycle pulse marking an aborted frame.

Function
REQ-010: The block SHALL reverse a 2:1 time-division multiplexer: frame = 2*WIDTH bits; bits 0..WIDTH-1 = channel A MSB first; bits WIDTH..2*WIDTH-1 = channel B MSB first.
REQ-011: The block SHALL implement two states, HUNT and RECV, plus a bit counter of ceil(log2(2*WIDTH)) bits and a 2*WIDTH-bit shift register.
REQ-012: In HUNT with sync=0, the block SHALL ignore din and hold a, b and the counter.
REQ-013: In HUNT with sync=1, the block SHALL shift din in as bit 0, set counter=1 and enter RECV.
REQ-014: In RECV with sync=0, the block SHALL shift din in and increment the counter each cycle.
REQ-015: On the edge sampling bit 2*WIDTH-1, the block SHALL load a and b from the assembled frame, assert valid for exactly the following cycle, clear the counter and return to HUNT.
REQ-016: Latency SHALL be zero extra cycles: a, b and valid update on the same edge that samples the last frame bit.
REQ-017: Back-to-back frames SHALL be accepted: sync=1 in the cycle immediately after a last bit starts a new frame with no gap.
REQ-018: In RECV with sync=1 (counter 1..2*WIDTH-1), the block SHALL abort the partial frame, pulse err for one cycle, keep a and b unchanged, suppress valid, treat the current din as bit 0 of a new frame and set counter=1.
REQ-019: valid and err SHALL never be high in the same cycle.
REQ-020: a and b SHALL change only on valid-producing edges or on reset.
REQ-021: Counter arithmetic SHALL never wrap past 2*WIDTH-1; reaching it always completes the frame.

Reset
REQ-022: While rst=1, regardless of clk: a=0, b=0, valid=0, err=0, state=HUNT, counter=0, shift register=0.
REQ-023: Reset asserted mid-frame SHALL discard the partial frame; after release no valid is issued until a new sync-started frame completes.
REQ-024: In the first rising edge after rst falls, the block SHALL operate normally (sync=1 on that edge starts a frame).

Verification (WIDTH=4)
REQ-025: The bench SHALL drive sync=1 at bit 0 with din=1,0,1,0,0,1,0,1 -> after the 8th edge a=4'hA, b=4'h5, valid high exactly one cycle, err=0.
REQ-026: The bench SHALL drive back-to-back frames A=3/B=C then A=F/B=0 -> two valid pulses exactly 8 cycles apart, with a/b = 3/C then F/0.
REQ-027: The bench SHALL reassert sync at bit 5 of a frame -> err pulses one cycle, a/b unchanged, no valid; the restarted frame completes 8 edges after the reassert with correct a/b.
REQ-028: The bench SHALL assert rst for 2 cycles at bit 3 of a frame -> a=0, b=0, valid=0 immediately; remaining bits with sync=0 produce no valid.
REQ-029: The bench SHALL toggle din for 20 cycles with sync=0 from HUNT -> valid=0, err=0, a and b held.
REQ-030: The bench SHALL check the final-bit edge of every frame -> valid never coincides with err, and a self-checking pass/fail message is printed.
